// File: rtl/pipe_div_hs.sv
// Pipelined radix-2 restoring divider: signed/unsigned per operation, sideband tag,
// divide-by-zero and overflow flags, valid/ready handshake with full-pipeline stall.
module pipe_div_hs #(
  parameter int DIVIDEND_W = 20,
  parameter int DIVISOR_W  = 10,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_dbz,
  output logic                  out_ovf
);

  localparam int DW = DIVIDEND_W;
  localparam int SW = DIVISOR_W;

  logic advance;

  // Per-stage state. aq holds the not-yet-consumed dividend bits in its upper part
  // and the quotient bits resolved so far in its lower part.
  logic             v_q    [0:DW];
  logic [DW-1:0]    aq_q   [0:DW];
  logic [SW:0]      rem_q  [0:DW];
  logic [SW-1:0]    bm_q   [0:DW];
  logic [TAG_W-1:0] tag_q  [0:DW];
  logic             negq_q [0:DW];
  logic             negr_q [0:DW];
  logic             dbz_q  [0:DW];
  logic             ovf_q  [0:DW];

  logic [DW-1:0]    aq_d   [1:DW];
  logic [SW:0]      rem_d  [1:DW];

  logic             a_neg;
  logic             b_neg;
  logic [DW-1:0]    a_mag;
  logic [SW-1:0]    b_mag;
  logic             is_ovf;
  logic [SW:0]      shifted;
  logic [SW+1:0]    diff;
  logic [DW-1:0]    q_mag;
  logic [SW-1:0]    r_mag;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign a_neg  = in_signed & in_dividend[DW-1];
  assign b_neg  = in_signed & in_divisor[SW-1];
  assign a_mag  = a_neg ? -in_dividend : in_dividend;
  assign b_mag  = b_neg ? -in_divisor : in_divisor;
  assign is_ovf = in_signed && (in_dividend == {1'b1, {(DW-1){1'b0}}}) && (&in_divisor);

  always_comb begin
    shifted = '0;
    diff    = '0;
    for (int k = 1; k <= DW; k++) begin
      shifted  = {rem_q[k-1][SW-1:0], aq_q[k-1][DW-1]};
      diff     = {1'b0, shifted} - {2'b00, bm_q[k-1]};
      aq_d[k]  = {aq_q[k-1][DW-2:0], ~diff[SW+1]};
      rem_d[k] = diff[SW+1] ? shifted : diff[SW:0];
    end
  end

  assign q_mag = aq_q[DW];
  assign r_mag = rem_q[DW][SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DW; k++) begin
        v_q[k]    <= 1'b0;
        aq_q[k]   <= '0;
        rem_q[k]  <= '0;
        bm_q[k]   <= '0;
        tag_q[k]  <= '0;
        negq_q[k] <= 1'b0;
        negr_q[k] <= 1'b0;
        dbz_q[k]  <= 1'b0;
        ovf_q[k]  <= 1'b0;
      end
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_dbz       <= 1'b0;
      out_ovf       <= 1'b0;
    end else if (advance) begin
      v_q[0]    <= in_valid;
      aq_q[0]   <= a_mag;
      rem_q[0]  <= '0;
      bm_q[0]   <= b_mag;
      tag_q[0]  <= in_tag;
      negq_q[0] <= a_neg ^ b_neg;
      negr_q[0] <= a_neg;
      dbz_q[0]  <= (in_divisor == '0);
      ovf_q[0]  <= is_ovf;
      for (int k = 1; k <= DW; k++) begin
        v_q[k]    <= v_q[k-1];
        aq_q[k]   <= aq_d[k];
        rem_q[k]  <= rem_d[k];
        bm_q[k]   <= bm_q[k-1];
        tag_q[k]  <= tag_q[k-1];
        negq_q[k] <= negq_q[k-1];
        negr_q[k] <= negr_q[k-1];
        dbz_q[k]  <= dbz_q[k-1];
        ovf_q[k]  <= ovf_q[k-1];
      end
      // Result fields are zeroed for bubbles so an idle output never shows stale data.
      out_valid <= v_q[DW];
      if (v_q[DW]) begin
        out_quotient  <= dbz_q[DW] ? '1 : (negq_q[DW] ? -q_mag : q_mag);
        out_remainder <= dbz_q[DW] ? '0 : (negr_q[DW] ? -r_mag : r_mag);
        out_tag       <= tag_q[DW];
        out_dbz       <= dbz_q[DW];
        out_ovf       <= ovf_q[DW];
      end else begin
        out_quotient  <= '0;
        out_remainder <= '0;
        out_tag       <= '0;
        out_dbz       <= 1'b0;
        out_ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_div_hs.sv
// Self-checking bench for pipe_div_hs: directed test-plan cases, stalled stream,
// asynchronous reset mid-flight and a randomized sweep against an arithmetic model.
module tb_pipe_div_hs;
  localparam int DW = 20;
  localparam int SW = 10;
  localparam int TW = 4;
  localparam int LAT = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [DW-1:0] in_dividend;
  logic [SW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic [SW-1:0] out_remainder;
  logic [TW-1:0] out_tag;
  logic          out_dbz;
  logic          out_ovf;

  pipe_div_hs #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_dbz(out_dbz), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic [TW-1:0] tag;
    logic          dbz;
    logic          ovf;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_fail = 0, n_out = 0, n_acc = 0;
  bit lat_mode = 0;
  bit stall_prev = 0;
  logic [DW+SW+TW+1:0] snap, last_got;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer division, C-style truncation for signed operands.
  function automatic exp_t model(input logic sg, input logic [DW-1:0] a,
                                 input logic [SW-1:0] b, input logic [TW-1:0] t);
    exp_t e;
    longint sa, sb, lq, lr;
    e.tag = t; e.acc = 0; e.lat = 0;
    if (b == '0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1; e.ovf = 1'b0;
    end else begin
      sa = sg ? longint'($signed(a)) : longint'(a);
      sb = sg ? longint'($signed(b)) : longint'(b);
      lq = sa / sb;
      lr = sa % sb;
      e.q = lq[DW-1:0];
      e.r = lr[SW-1:0];
      e.dbz = 1'b0;
      e.ovf = sg && (sa == -(longint'(1) << (DW-1))) && (sb == -1);
    end
    return e;
  endfunction

  task automatic step(input logic iv, input logic sg, input logic [DW-1:0] a,
                      input logic [SW-1:0] b, input logic [TW-1:0] t, input logic ordy);
    exp_t e;
    logic [DW+SW+TW+1:0] cur;
    @(negedge clk);
    in_valid = iv; in_signed = sg; in_dividend = a; in_divisor = b; in_tag = t;
    out_ready = ordy;
    #1;
    cur = {out_quotient, out_remainder, out_tag, out_dbz, out_ovf};
    chk("in_ready", in_ready, !out_valid || ordy);
    if (stall_prev) chk("frozen", {out_valid, cur}, {1'b1, snap});
    stall_prev = out_valid && !ordy;
    snap = cur;
    if (iv && in_ready) begin
      e = model(sg, a, b, t);
      e.acc = cyc;
      e.lat = lat_mode;
      sbq.push_back(e);
      n_acc++;
    end
    if (out_valid && ordy) begin
      n_out++;
      last_got = cur;
      chk("result_expected", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("result", cur, {e.q, e.r, e.tag, e.dbz, e.ovf});
        if (e.lat) chk("latency", cyc - e.acc - 1, LAT);
      end
    end
    @(posedge clk);
  endtask

  task automatic one(input logic sg, input logic [DW-1:0] a, input logic [SW-1:0] b,
                     input logic [TW-1:0] t, input logic [DW-1:0] xq, input logic [SW-1:0] xr,
                     input logic xdbz, input logic xovf);
    int base;
    base = n_out;
    lat_mode = 1;
    step(1'b1, sg, a, b, t, 1'b1);
    for (int i = 0; i < 3 * LAT && n_out == base; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("dir_count", n_out - base, 1);
    chk("dir_q",   last_got[DW+SW+TW+1 -: DW], xq);
    chk("dir_r",   last_got[SW+TW+1 -: SW], xr);
    chk("dir_tag", last_got[TW+1 -: TW], t);
    chk("dir_dbz", last_got[1], xdbz);
    chk("dir_ovf", last_got[0], xovf);
    lat_mode = 0;
  endtask

  task automatic rand_op(output logic sg, output logic [DW-1:0] a,
                         output logic [SW-1:0] b, output logic [TW-1:0] t);
    sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: a = '0;
      1: a = {1'b1, {(DW-1){1'b0}}};
      2: a = {1'b0, {(DW-1){1'b1}}};
      3: a = '1;
      default: a = DW'($urandom);
    endcase
    case ($urandom_range(0, 9))
      0: b = '0;
      1: b = SW'(1);
      2: b = '1;
      3: b = {1'b0, {(SW-1){1'b1}}};
      4: b = {1'b1, {(SW-1){1'b0}}};
      default: b = SW'($urandom);
    endcase
    t = TW'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() > 0; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    logic sg;
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    logic [TW-1:0] t;
    int base, steps;

    rst_n = 1'b0;
    in_valid = 1'b0; in_signed = 1'b0; in_dividend = '0; in_divisor = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_outs", {out_quotient, out_remainder, out_tag, out_dbz, out_ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    one(1'b0, 20'd1000, 10'd7, 4'd3, 20'h0008E, 10'd6, 1'b0, 1'b0);
    one(1'b1, 20'hFFC18, 10'h007, 4'd1, 20'hFFF72, 10'h3FA, 1'b0, 1'b0);
    one(1'b1, 20'd1000, 10'h3F9, 4'd2, 20'hFFF72, 10'd6, 1'b0, 1'b0);
    one(1'b1, 20'h80000, 10'h3FF, 4'd4, 20'h80000, 10'd0, 1'b0, 1'b1);
    one(1'b0, 20'd12345, 10'd0, 4'd5, 20'hFFFFF, 10'd0, 1'b1, 1'b0);
    one(1'b1, 20'hFFFFB, 10'd0, 4'd6, 20'hFFFFF, 10'd0, 1'b1, 1'b0);
    one(1'b0, 20'hFFFFF, 10'h3FF, 4'd7, 20'h00401, 10'd0, 1'b0, 1'b0);

    // Back-to-back stream of 30 with a 5-cycle consumer stall once results flow.
    base = n_out;
    n_acc = 0;
    for (int i = 0; n_acc < 30 && i < 200; i++) begin
      rand_op(sg, a, b, t);
      step(1'b1, sg, a, b, t, !(i >= 22 && i < 27));
    end
    drain();
    chk("stream_count", n_out - base, 30);

    // Asynchronous reset while the pipeline is full and a result is presented.
    for (int i = 0; i < 25; i++) begin
      rand_op(sg, a, b, t);
      step(1'b1, sg, a, b, t, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_outs", {out_quotient, out_remainder, out_tag, out_dbz, out_ovf}, 0);
    #9 rst_n = 1'b1;
    sbq.delete();
    stall_prev = 0;
    base = n_out;
    one(1'b0, 20'd1, 10'd1, 4'd9, 20'd1, 10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("no_stale", n_out - base, 1);

    // Random sweep with bubbles and random backpressure.
    base = n_out;
    n_acc = 0;
    steps = 0;
    while (n_acc < 10000 && steps < 40000) begin
      rand_op(sg, a, b, t);
      step($urandom_range(0, 3) != 0, sg, a, b, t, $urandom_range(0, 3) != 0);
      steps++;
    end
    chk("sweep_accepted", n_acc, 10000);
    drain();
    chk("sweep_count", n_out - base, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
